// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output handshake and status bundle of the receiver.
// Handshake: a word transfers on a posedge where po_valid && po_ready; po is held while po_valid && !po_ready.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) ();

  logic             si;
  logic             si_valid;
  logic             sync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output si, si_valid, sync, po_ready,
    input  po, po_valid, overrun, bit_cnt
  );

  modport slave (
    input  si, si_valid, sync, po_ready,
    output po, po_valid, overrun, bit_cnt
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter; last_bit_o flags the edge that completes a word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             si_valid_i,
  input  logic             sync_i,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             last_bit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // SYNC restarts the frame, so it can never be the completing edge.
  assign last_bit_o = si_valid_i && !sync_i && (cnt_q == CNT_W'(WIDTH - 1));
  assign bit_cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_i) begin
      cnt_d = si_valid_i ? CNT_W'(1) : '0;
    end else if (si_valid_i) begin
      cnt_d = last_bit_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial receiver: assembles WIDTH-bit words and presents them with valid/ready.
// A word completing while the held word is stalled is dropped and sets sticky overrun.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sipo_deserializer_if.slave   bus,
  output out_state_t           state_o
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             overrun_q, overrun_d;
  out_state_t       state_q, state_d;
  logic             last_bit;
  logic [WIDTH-1:0] word;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .si_valid_i (bus.si_valid),
    .sync_i     (bus.sync),
    .bit_cnt_o  (bus.bit_cnt),
    .last_bit_o (last_bit)
  );

  // Stale bits left by SYNC are shifted out before the next completion.
  assign word = {bus.si, sr_q[WIDTH-1:1]};
  assign sr_d = bus.si_valid ? word : sr_q;

  always_comb begin
    state_d   = state_q;
    po_d      = po_q;
    overrun_d = overrun_q;
    unique case (state_q)
      EMPTY: begin
        if (last_bit) begin
          state_d = FULL;
          po_d    = word;
        end
      end
      FULL: begin
        if (last_bit) begin
          if (bus.po_ready) begin
            po_d = word;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (bus.po_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q      <= '0;
      po_q      <= '0;
      overrun_q <= 1'b0;
      state_q   <= EMPTY;
    end else begin
      sr_q      <= sr_d;
      po_q      <= po_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = (state_q == FULL);
  assign bus.overrun  = overrun_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed scenarios plus random traffic against a bit-list reference model.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int W = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n;
  out_state_t state;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // scoreboard and reference model
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [W-1:0] exp_q[$];
  bit         bits_q[$];
  bit         m_full = 1'b0;
  bit         m_ovr  = 1'b0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Word model: a list of received bits; a word is the first W bits, bit i = i-th received.
  task automatic model_step(input bit r, input bit si, input bit v, input bit sy, input bit rdy);
    logic [W-1:0] word;
    bit done;
    done = 1'b0;
    word = '0;
    if (!r) begin
      bits_q.delete();
      exp_q.delete();
      m_full = 1'b0;
      m_ovr  = 1'b0;
      return;
    end
    if (sy) begin
      bits_q.delete();
      if (v) bits_q.push_back(si);
    end else if (v) begin
      bits_q.push_back(si);
      if (bits_q.size() == W) begin
        for (int i = 0; i < W; i++) word[i] = bits_q[i];
        bits_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (m_full && !rdy) m_ovr = 1'b1;
      else begin
        exp_q.push_back(word);
        m_full = 1'b1;
      end
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
  endtask

  // driver tasks
  task automatic cycle(input bit r, input bit si, input bit v, input bit sy, input bit rdy);
    rst_n        = r;
    bus.si       = si;
    bus.si_valid = v;
    bus.sync     = sy;
    bus.po_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, si, v, sy, rdy);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = 0; i < W; i++) cycle(1'b1, w[i], 1'b1, 1'b0, rdy);
  endtask

  task automatic drain();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // monitor: sampled on the falling edge, pops the scoreboard on each accepted transfer
  always @(negedge clk) begin
    if (mon_en) begin
      check("bit_cnt", 32'(bus.bit_cnt), 32'(bits_q.size()));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
      check("po_valid", 32'(bus.po_valid), 32'(m_full));
      check("state", 32'(state), 32'(m_full));
      if (bus.po_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL po_unexpected: got %0h expected no word", bus.po);
        end else begin
          check("po", 32'(bus.po), 32'(exp_q[0]));
          if (bus.po_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] piso;
    bit r, si, v, sy, rdy;

    rst_n        = 1'b0;
    bus.si       = 1'b0;
    bus.si_valid = 1'b0;
    bus.sync     = 1'b0;
    bus.po_ready = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    check("reset_po", 32'(bus.po), 32'd0);
    check("reset_valid", 32'(bus.po_valid), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    check("reset_bit_cnt", 32'(bus.bit_cnt), 32'd0);

    // first word: 1,0,1
    send_word(3'b101, 1'b0);
    check("t1_po", 32'(bus.po), 32'b101);
    check("t1_valid", 32'(bus.po_valid), 32'd1);
    check("t1_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    drain();
    check("t1_drained", 32'(bus.po_valid), 32'd0);

    // loopback from a PISO register loaded with 3'b110
    piso = 3'b110;
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, piso[0], 1'b1, 1'b0, 1'b0);
      piso = piso >> 1;
    end
    check("t2_po", 32'(bus.po), 32'b110);
    drain();

    // stalled consumer: second word dropped
    send_word(3'b011, 1'b0);
    send_word(3'b100, 1'b0);
    check("t3_po", 32'(bus.po), 32'b011);
    check("t3_overrun", 32'(bus.overrun), 32'd1);
    drain();
    check("t3_valid", 32'(bus.po_valid), 32'd0);
    check("t3_po_held", 32'(bus.po), 32'b011);

    // back-to-back hand-over without a bubble
    send_word(3'b001, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_first", 32'(bus.po), 32'b001);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_valid", 32'(bus.po_valid), 32'd1);
    check("t4_second", 32'(bus.po), 32'b111);
    drain();

    // SYNC realigns mid-word
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_sync_cnt", 32'(bus.bit_cnt), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_po", 32'(bus.po), 32'b010);
    check("t5_valid", 32'(bus.po_valid), 32'd1);
    drain();

    // reset mid-word with a held word and overrun set
    send_word(3'b110, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_pre_cnt", 32'(bus.bit_cnt), 32'd2);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_po", 32'(bus.po), 32'd0);
    check("t6_valid", 32'(bus.po_valid), 32'd0);
    check("t6_overrun", 32'(bus.overrun), 32'd0);
    check("t6_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    send_word(3'b100, 1'b0);
    check("t6_after", 32'(bus.po), 32'b100);
    drain();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 199) != 0);
      si  = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      sy  = ($urandom_range(0, 15) == 0);
      rdy = 1'($urandom_range(0, 1));
      cycle(r, si, v, sy, rdy);
    end
    drain();
    drain();
    check("final_valid", 32'(bus.po_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
